netwalk_tcam_prog_ctrl: RTL and testbench
=========================================

Name: netwalk_tcam_prog_ctrl

Overview:
- Programming controller for the NETWALK TCAM array, built from TCAM_DEPTH single-entry TCAM units.
- Arbitrates add/delete requests from two requesters: rq0 is the control-plane CPU, rq1 is the flow-expiry engine.
- Sequences each write onto the shared TCAM program bus, tracks per-entry valid bits, auto-allocates free entries, and stalls lookups while an entry is being rewritten.

Parameters:
- DPL_MATCH_FIELD_WIDTH, 356, match data/mask width.
- TCAM_ADDR_WIDTH, 8, entry address width.
- TCAM_DEPTH, 256, number of TCAM units; must be ≤ 2^TCAM_ADDR_WIDTH.

Ports:
- clk  in  1  single clock, all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- rq0_valid / rq1_valid  in  1  request valid.
- rq0_ready / rq1_ready  out  1  request accepted this cycle.
- rq0_op / rq1_op  in  2  00 ADD@addr, 01 DELETE@addr, 10 ADD_ALLOC, 11 reserved.
- rq0_addr / rq1_addr  in  TCAM_ADDR_WIDTH  target entry; ignored for ADD_ALLOC.
- rq0_data / rq1_data  in  DPL_MATCH_FIELD_WIDTH  match data.
- rq0_mask / rq1_mask  in  DPL_MATCH_FIELD_WIDTH  care mask; 1 = compare this bit.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed.
- rsp_id  out  1  requester index of the response.
- rsp_status  out  2  00 OK, 01 OK_OVERWRITE, 10 ERR_NOT_VALID/ERR_OP, 11 ERR_FULL.
- rsp_addr  out  TCAM_ADDR_WIDTH  entry written or targeted.
- tcam_program_data  out  DPL_MATCH_FIELD_WIDTH  shared program data bus.
- tcam_program_mask  out  DPL_MATCH_FIELD_WIDTH  shared program mask bus.
- tcam_program_addr  out  TCAM_ADDR_WIDTH  program address.
- tcam_unit_sel  out  TCAM_DEPTH  one-hot unit select.
- tcam_program_enable  out  1  program strobe.
- tcam_delete_enable  out  1  delete qualifier for the program strobe.
- lookup_stall  out  1  lookups must not be launched or consumed.
- entry_count  out  TCAM_ADDR_WIDTH+1  number of valid entries.
- tcam_full  out  1  entry_count == TCAM_DEPTH.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - FSM goes to IDLE; valid bitmap and entry_count go to 0.
  - All outputs are 0; rr_last = 1, so rq0 wins first.
  - Reset asserted mid-operation aborts it: no response and no write strobe after reset.
- FSM states: IDLE, CHECK, WRITE, SETTLE, RESP.
- IDLE:
  - If any rqN_valid, grant round-robin: the requester not granted last wins a tie; a single requester wins outright.
  - Pulse the granted rqN_ready for 1 cycle; latch op/addr/data/mask/id.
  - Go to CHECK. The non-granted request stays pending, with no ready pulse.
- CHECK (1 cycle), resolves the operation:
  - ADD: status = OK if the entry is invalid, OK_OVERWRITE if valid. Go to WRITE.
  - ADD_ALLOC: pick the lowest-index invalid entry through a priority encoder; status OK; go to WRITE. If tcam_full, status ERR_FULL and go to RESP.
  - DELETE: if the entry is valid, go to WRITE; otherwise status ERR_NOT_VALID and go to RESP.
  - op 11 or addr ≥ TCAM_DEPTH: status ERR_NOT_VALID, go to RESP.
- WRITE (1 cycle):
  - Assert tcam_program_enable=1 and tcam_unit_sel[addr]=1; drive addr, data and mask.
  - Assert tcam_delete_enable=1 for DELETE.
  - Update the valid bit and entry_count: +1 when an ADD/ADD_ALLOC fills an empty entry, −1 on DELETE, unchanged on OK_OVERWRITE.
- SETTLE (1 cycle): program_enable=0 and unit_sel=0; the units recompute their match outputs.
- lookup_stall timing:
  - Asserted in CHECK, WRITE and SETTLE.
  - Deasserted in RESP and IDLE.
  - Never asserted on error paths beyond CHECK.
- RESP:
  - Drive rsp_valid=1 with id/status/addr stable until rsp_valid && rsp_ready.
  - Then go to IDLE. The next grant can occur in the cycle after the handshake.
- Latency:
  - Successful op: accept at cycle T, WRITE at T+2, rsp_valid at T+4.
  - Error op: rsp_valid at T+2.
- Program buses: data and mask hold their last value outside WRITE; unit_sel is zero outside WRITE.
- Throughput: one request in flight; a request every ≥5 cycles with rsp_ready tied high.

Test Plan:
- Reset, then rq0 ADD addr=5, data=0xA5, mask=0xFF → WRITE has unit_sel[5]=1 and program_enable=1; rsp OK, addr 5, id 0 at T+4; entry_count=1.
- rq0 and rq1 valid in the same cycle, then again → first grant rq0, second rq1, third rq0; never two ready pulses in one cycle.
- ADD_ALLOC ×3 after reset → rsp_addr 0, 1, 2. Then DELETE 1 followed by ADD_ALLOC → rsp_addr 1; entry_count=3.
- Fill all 256 entries, then ADD_ALLOC → ERR_FULL at T+2, no program_enable, tcam_full=1, count=256.
- Error and overwrite paths:
  - DELETE on an empty addr 9 → ERR_NOT_VALID with no write.
  - ADD to valid addr 0 → OK_OVERWRITE, count unchanged.
  - op=11 → ERR_NOT_VALID.
- Reset and backpressure:
  - Drop reset during WRITE → program_enable and rsp_valid are 0 immediately; count=0.
  - Hold rsp_ready=0 for 10 cycles → rsp fields stay stable and no new grant occurs.

Source files
------------

// File: rtl/netwalk_tcam_prog_ctrl_if.sv
// Request, response and TCAM program-bus bundle for the NETWALK TCAM programming controller.
// The controller sits on the slave modport; requesters, the response sink and the TCAM array are the master side.
interface netwalk_tcam_prog_ctrl_if #(
  parameter int DPL_MATCH_FIELD_WIDTH = 356,
  parameter int TCAM_ADDR_WIDTH       = 8,
  parameter int TCAM_DEPTH            = 256
);
  logic                             rq0_valid;
  logic                             rq0_ready;
  logic [1:0]                       rq0_op;
  logic [TCAM_ADDR_WIDTH-1:0]       rq0_addr;
  logic [DPL_MATCH_FIELD_WIDTH-1:0] rq0_data;
  logic [DPL_MATCH_FIELD_WIDTH-1:0] rq0_mask;
  logic                             rq1_valid;
  logic                             rq1_ready;
  logic [1:0]                       rq1_op;
  logic [TCAM_ADDR_WIDTH-1:0]       rq1_addr;
  logic [DPL_MATCH_FIELD_WIDTH-1:0] rq1_data;
  logic [DPL_MATCH_FIELD_WIDTH-1:0] rq1_mask;
  logic                             rsp_valid;
  logic                             rsp_ready;
  logic                             rsp_id;
  logic [1:0]                       rsp_status;
  logic [TCAM_ADDR_WIDTH-1:0]       rsp_addr;
  logic [DPL_MATCH_FIELD_WIDTH-1:0] tcam_program_data;
  logic [DPL_MATCH_FIELD_WIDTH-1:0] tcam_program_mask;
  logic [TCAM_ADDR_WIDTH-1:0]       tcam_program_addr;
  logic [TCAM_DEPTH-1:0]            tcam_unit_sel;
  logic                             tcam_program_enable;
  logic                             tcam_delete_enable;
  logic                             lookup_stall;
  logic [TCAM_ADDR_WIDTH:0]         entry_count;
  logic                             tcam_full;

  modport slave (
    input  rq0_valid, rq0_op, rq0_addr, rq0_data, rq0_mask,
    input  rq1_valid, rq1_op, rq1_addr, rq1_data, rq1_mask,
    input  rsp_ready,
    output rq0_ready, rq1_ready,
    output rsp_valid, rsp_id, rsp_status, rsp_addr,
    output tcam_program_data, tcam_program_mask, tcam_program_addr,
    output tcam_unit_sel, tcam_program_enable, tcam_delete_enable,
    output lookup_stall, entry_count, tcam_full
  );

  modport master (
    output rq0_valid, rq0_op, rq0_addr, rq0_data, rq0_mask,
    output rq1_valid, rq1_op, rq1_addr, rq1_data, rq1_mask,
    output rsp_ready,
    input  rq0_ready, rq1_ready,
    input  rsp_valid, rsp_id, rsp_status, rsp_addr,
    input  tcam_program_data, tcam_program_mask, tcam_program_addr,
    input  tcam_unit_sel, tcam_program_enable, tcam_delete_enable,
    input  lookup_stall, entry_count, tcam_full
  );
endinterface

// File: rtl/netwalk_tcam_prog_ctrl.sv
// NETWALK TCAM programming controller: round-robin arbitration of two requesters, entry validity
// tracking with lowest-free allocation, and a one-request-in-flight program/settle/respond sequence.
module netwalk_tcam_prog_ctrl #(
  parameter int DPL_MATCH_FIELD_WIDTH = 356,
  parameter int TCAM_ADDR_WIDTH       = 8,
  parameter int TCAM_DEPTH            = 256
) (
  input logic                    clk,
  input logic                    reset,
  netwalk_tcam_prog_ctrl_if.slave io_bus
);
  localparam int AW = TCAM_ADDR_WIDTH;
  localparam int DW = DPL_MATCH_FIELD_WIDTH;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_DEL   = 2'b01;
  localparam logic [1:0] OP_ALLOC = 2'b10;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_OVW   = 2'b01;
  localparam logic [1:0] ST_ERR   = 2'b10;
  localparam logic [1:0] ST_FULL  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_WRITE  = 3'd2,
    S_SETTLE = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t                r_state;
  logic                  r_armed;
  logic                  r_rr_last;
  logic [1:0]            r_op;
  logic [AW-1:0]         r_addr;
  logic [DW-1:0]         r_data;
  logic [DW-1:0]         r_mask;
  logic                  r_id;
  logic [1:0]            r_status;
  logic [TCAM_DEPTH-1:0] r_valid;
  logic [AW:0]           r_count;
  logic                  r_full;
  logic                  r_prog_en;
  logic                  r_del_en;
  logic [TCAM_DEPTH-1:0] r_unit_sel;
  logic [AW-1:0]         r_prog_addr;
  logic [DW-1:0]         r_prog_data;
  logic [DW-1:0]         r_prog_mask;
  logic                  r_stall;
  logic                  r_rsp_valid;
  logic                  r_rsp_id;
  logic [1:0]            r_rsp_status;
  logic [AW-1:0]         r_rsp_addr;

  logic                  w_gid;
  logic                  w_grant_en;
  logic                  w_addr_ok;
  logic                  w_sel_valid;
  logic [AW-1:0]         w_alloc_addr;
  logic [1:0]            w_chk_status;
  logic                  w_chk_write;
  logic [AW-1:0]         w_chk_addr;
  logic [AW:0]           w_count_next;

  // A tie goes to the requester that was not served last; r_armed keeps ready low while in reset.
  assign w_gid      = (io_bus.rq0_valid && io_bus.rq1_valid) ? ~r_rr_last : io_bus.rq1_valid;
  assign w_grant_en = r_armed && (r_state == S_IDLE) && (io_bus.rq0_valid || io_bus.rq1_valid);
  assign io_bus.rq0_ready = w_grant_en && !w_gid;
  assign io_bus.rq1_ready = w_grant_en && w_gid;

  generate
    if (TCAM_DEPTH >= (2 ** TCAM_ADDR_WIDTH)) begin : g_addr_full_range
      assign w_addr_ok = 1'b1;
    end else begin : g_addr_partial_range
      assign w_addr_ok = (32'(r_addr) < 32'(TCAM_DEPTH));
    end
  endgenerate

  assign w_sel_valid = r_valid[r_addr];

  // Lowest-index free entry; scanning downward lets the smallest index win.
  always_comb begin
    w_alloc_addr = '0;
    for (int i = TCAM_DEPTH - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_alloc_addr = AW'(i);
      end else begin
        w_alloc_addr = w_alloc_addr;
      end
    end
  end

  // Operation resolution used during CHECK.
  always_comb begin
    w_chk_status = ST_ERR;
    w_chk_write  = 1'b0;
    w_chk_addr   = r_addr;
    case (r_op)
      OP_ADD: begin
        if (w_addr_ok) begin
          w_chk_write  = 1'b1;
          w_chk_status = w_sel_valid ? ST_OVW : ST_OK;
        end else begin
          w_chk_status = ST_ERR;
        end
      end
      OP_DEL: begin
        if (w_addr_ok && w_sel_valid) begin
          w_chk_write  = 1'b1;
          w_chk_status = ST_OK;
        end else begin
          w_chk_status = ST_ERR;
        end
      end
      OP_ALLOC: begin
        w_chk_addr = w_alloc_addr;
        if (r_full) begin
          w_chk_status = ST_FULL;
        end else begin
          w_chk_write  = 1'b1;
          w_chk_status = ST_OK;
        end
      end
      default: begin
        w_chk_status = ST_ERR;
      end
    endcase
  end

  // Occupancy after the write: overwrites leave the count alone.
  always_comb begin
    w_count_next = r_count;
    if (r_op == OP_DEL) begin
      w_count_next = r_count - (AW + 1)'(1);
    end else if (r_status == ST_OK) begin
      w_count_next = r_count + (AW + 1)'(1);
    end else begin
      w_count_next = r_count;
    end
  end

  // Sequencer with all externally visible controls registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_armed      <= 1'b0;
      r_rr_last    <= 1'b1;
      r_op         <= 2'b00;
      r_addr       <= '0;
      r_data       <= '0;
      r_mask       <= '0;
      r_id         <= 1'b0;
      r_status     <= 2'b00;
      r_valid      <= '0;
      r_count      <= '0;
      r_full       <= 1'b0;
      r_prog_en    <= 1'b0;
      r_del_en     <= 1'b0;
      r_unit_sel   <= '0;
      r_prog_addr  <= '0;
      r_prog_data  <= '0;
      r_prog_mask  <= '0;
      r_stall      <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_status <= 2'b00;
      r_rsp_addr   <= '0;
    end else begin
      r_armed <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_grant_en) begin
            r_rr_last <= w_gid;
            r_id      <= w_gid;
            r_op      <= w_gid ? io_bus.rq1_op   : io_bus.rq0_op;
            r_addr    <= w_gid ? io_bus.rq1_addr : io_bus.rq0_addr;
            r_data    <= w_gid ? io_bus.rq1_data : io_bus.rq0_data;
            r_mask    <= w_gid ? io_bus.rq1_mask : io_bus.rq0_mask;
            r_stall   <= 1'b1;
            r_state   <= S_CHECK;
          end else begin
            r_state   <= S_IDLE;
          end
        end
        S_CHECK: begin
          r_addr   <= w_chk_addr;
          r_status <= w_chk_status;
          if (w_chk_write) begin
            r_prog_en   <= 1'b1;
            r_del_en    <= (r_op == OP_DEL);
            r_unit_sel  <= TCAM_DEPTH'(1) << w_chk_addr;
            r_prog_addr <= w_chk_addr;
            r_prog_data <= r_data;
            r_prog_mask <= r_mask;
            r_state     <= S_WRITE;
          end else begin
            r_stall      <= 1'b0;
            r_rsp_valid  <= 1'b1;
            r_rsp_id     <= r_id;
            r_rsp_status <= w_chk_status;
            r_rsp_addr   <= w_chk_addr;
            r_state      <= S_RESP;
          end
        end
        S_WRITE: begin
          r_prog_en       <= 1'b0;
          r_del_en        <= 1'b0;
          r_unit_sel      <= '0;
          r_valid[r_addr] <= (r_op != OP_DEL);
          r_count         <= w_count_next;
          r_full          <= (w_count_next == (AW + 1)'(TCAM_DEPTH));
          r_state         <= S_SETTLE;
        end
        S_SETTLE: begin
          r_stall      <= 1'b0;
          r_rsp_valid  <= 1'b1;
          r_rsp_id     <= r_id;
          r_rsp_status <= r_status;
          r_rsp_addr   <= r_addr;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          if (io_bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_state     <= S_RESP;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign io_bus.rsp_valid           = r_rsp_valid;
  assign io_bus.rsp_id              = r_rsp_id;
  assign io_bus.rsp_status          = r_rsp_status;
  assign io_bus.rsp_addr            = r_rsp_addr;
  assign io_bus.tcam_program_data   = r_prog_data;
  assign io_bus.tcam_program_mask   = r_prog_mask;
  assign io_bus.tcam_program_addr   = r_prog_addr;
  assign io_bus.tcam_unit_sel       = r_unit_sel;
  assign io_bus.tcam_program_enable = r_prog_en;
  assign io_bus.tcam_delete_enable  = r_del_en;
  assign io_bus.lookup_stall        = r_stall;
  assign io_bus.entry_count         = r_count;
  assign io_bus.tcam_full           = r_full;
endmodule

// File: tb/tb_netwalk_tcam_prog_ctrl.sv
// Scoreboard bench for netwalk_tcam_prog_ctrl: an acceptance monitor feeds a table-level model,
// response and program-bus monitors pop the expected items independently of the stimulus.
module tb_netwalk_tcam_prog_ctrl;
  localparam int W  = 356;
  localparam int AW = 8;
  localparam int D  = 256;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  netwalk_tcam_prog_ctrl_if #(.DPL_MATCH_FIELD_WIDTH(W), .TCAM_ADDR_WIDTH(AW), .TCAM_DEPTH(D)) dif ();

  netwalk_tcam_prog_ctrl #(.DPL_MATCH_FIELD_WIDTH(W), .TCAM_ADDR_WIDTH(AW), .TCAM_DEPTH(D)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (dif)
  );

  typedef struct {
    bit          id;
    logic [1:0]  st;
    logic [AW-1:0] addr;
    bit          chk_addr;
    int          acc;
    int          lat;
    int          cnt;
  } rsp_t;

  typedef struct {
    logic [AW-1:0] addr;
    bit            del;
    logic [W-1:0]  data;
    logic [W-1:0]  mask;
  } wr_t;

  rsp_t rq[$];
  wr_t  wq[$];
  bit   mv[D];
  int   mcnt;
  bit   mrr;
  bit   in_rsp;
  int   grants;
  int   cyc;
  int   checks;
  int   failures;
  bit   rand_bp;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [383:0] act, input logic [383:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rv();
    logic [W-1:0] v;
    for (int i = 0; i < W; i++) v[i] = 1'($urandom_range(1));
    return v;
  endfunction

  // Table-level model: entry occupancy as an array, allocation as a linear search.
  task automatic model_apply(input bit id, input logic [1:0] op, input logic [AW-1:0] addr,
                             input logic [W-1:0] data, input logic [W-1:0] mask);
    rsp_t e;
    wr_t  w;
    bit   wr;
    int   k;
    wr = 0;
    e.id = id; e.addr = addr; e.chk_addr = 1; e.acc = cyc; e.st = 2'b10;
    case (op)
      2'b00: if (int'(addr) < D) begin
        e.st = mv[addr] ? 2'b01 : 2'b00;
        if (!mv[addr]) mcnt++;
        mv[addr] = 1; wr = 1;
      end
      2'b01: if (int'(addr) < D && mv[addr]) begin
        e.st = 2'b00; mv[addr] = 0; mcnt--; wr = 1;
      end
      2'b10: if (mcnt == D) begin
        e.st = 2'b11; e.chk_addr = 0;
      end else begin
        k = 0;
        while (mv[k]) k++;
        e.addr = AW'(k); mv[k] = 1; mcnt++; e.st = 2'b00; wr = 1;
      end
      default: e.st = 2'b10;
    endcase
    e.lat = wr ? 4 : 2;
    e.cnt = mcnt;
    rq.push_back(e);
    if (wr) begin
      w.addr = e.addr; w.del = (op == 2'b01); w.data = data; w.mask = mask;
      wq.push_back(w);
    end
  endtask

  // Acceptance monitor: checks arbitration and feeds the model in grant order.
  always @(negedge clk) begin
    bit r0, r1, pred;
    if (reset) begin
      r0 = dif.rq0_ready;
      r1 = dif.rq1_ready;
      check("single_ready", {r0, r1} == 2'b11, 1'b0);
      if (r0 || r1) begin
        pred = (dif.rq0_valid && dif.rq1_valid) ? !mrr : dif.rq1_valid;
        check("grant_id", r1, pred);
        check("grant_has_valid", r1 ? dif.rq1_valid : dif.rq0_valid, 1'b1);
        mrr = r1;
        grants++;
        if (r1) model_apply(1'b1, dif.rq1_op, dif.rq1_addr, dif.rq1_data, dif.rq1_mask);
        else    model_apply(1'b0, dif.rq0_op, dif.rq0_addr, dif.rq0_data, dif.rq0_mask);
      end
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    rsp_t e;
    if (reset && dif.rsp_valid) begin
      if (rq.size() == 0) begin
        check("rsp_unexpected", dif.rsp_valid, 1'b0);
      end else begin
        e = rq[0];
        if (!in_rsp) begin
          check("rsp_latency", cyc - e.acc, e.lat);
          in_rsp = 1;
        end
        check("rsp_stall_low", dif.lookup_stall, 1'b0);
        check("rsp_id", dif.rsp_id, e.id);
        check("rsp_status", dif.rsp_status, e.st);
        if (e.chk_addr) check("rsp_addr", dif.rsp_addr, e.addr);
        if (dif.rsp_ready) begin
          check("entry_count", dif.entry_count, e.cnt);
          check("tcam_full", dif.tcam_full, e.cnt == D);
          void'(rq.pop_front());
          in_rsp = 0;
        end
      end
    end
  end

  // Program-bus monitor.
  always @(negedge clk) begin
    wr_t w;
    logic [D-1:0] oh;
    if (reset) begin
      if (dif.tcam_program_enable) begin
        if (wq.size() == 0) begin
          check("write_unexpected", dif.tcam_program_enable, 1'b0);
        end else begin
          w = wq.pop_front();
          oh = '0;
          oh[w.addr] = 1'b1;
          check("unit_sel", dif.tcam_unit_sel, oh);
          check("prog_addr", dif.tcam_program_addr, w.addr);
          check("delete_en", dif.tcam_delete_enable, w.del);
          check("prog_data", dif.tcam_program_data, w.data);
          check("prog_mask", dif.tcam_program_mask, w.mask);
          check("write_stall", dif.lookup_stall, 1'b1);
        end
      end else begin
        check("unit_sel_idle", dif.tcam_unit_sel, '0);
        check("delete_en_idle", dif.tcam_delete_enable, 1'b0);
      end
    end
  end

  always @(posedge clk) begin
    if (rand_bp) begin
      #1;
      dif.rsp_ready = ($urandom_range(3) != 0);
    end
  end

  task automatic drive(input bit id, input logic [1:0] op, input logic [AW-1:0] addr,
                       input logic [W-1:0] data, input logic [W-1:0] mask);
    int n;
    bit got;
    n = 0; got = 0;
    @(posedge clk); #1;
    if (id) begin
      dif.rq1_op = op; dif.rq1_addr = addr; dif.rq1_data = data; dif.rq1_mask = mask; dif.rq1_valid = 1;
    end else begin
      dif.rq0_op = op; dif.rq0_addr = addr; dif.rq0_data = data; dif.rq0_mask = mask; dif.rq0_valid = 1;
    end
    while (!got && n < 400) begin
      @(negedge clk);
      got = id ? dif.rq1_ready : dif.rq0_ready;
      n++;
    end
    if (!got) check("accept_timeout", got, 1'b1);
    @(posedge clk); #1;
    if (id) dif.rq1_valid = 0;
    else    dif.rq0_valid = 0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((rq.size() != 0 || wq.size() != 0 || dif.rsp_valid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check("drain_timeout", n, 0);
  endtask

  task automatic clear_model();
    rq.delete(); wq.delete();
    foreach (mv[i]) mv[i] = 0;
    mcnt = 0; mrr = 1; in_rsp = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 0;
    clear_model();
    repeat (3) @(negedge clk);
    reset = 1;
  endtask

  initial begin
    int n, g0, m;
    bit r;
    logic [1:0] op;
    dif.rq0_valid = 0; dif.rq0_op = 2'b00; dif.rq0_addr = '0; dif.rq0_data = '0; dif.rq0_mask = '0;
    dif.rq1_valid = 0; dif.rq1_op = 2'b00; dif.rq1_addr = '0; dif.rq1_data = '0; dif.rq1_mask = '0;
    dif.rsp_ready = 1; rand_bp = 0;
    checks = 0; failures = 0; grants = 0; cyc = 0;
    clear_model();

    repeat (2) @(negedge clk);
    dif.rq0_valid = 1;
    #1;
    check("rst_rq0_ready", dif.rq0_ready, 1'b0);
    check("rst_rsp_valid", dif.rsp_valid, 1'b0);
    check("rst_prog_en", dif.tcam_program_enable, 1'b0);
    check("rst_unit_sel", dif.tcam_unit_sel, '0);
    check("rst_count", dif.entry_count, '0);
    check("rst_stall", dif.lookup_stall, 1'b0);
    check("rst_full", dif.tcam_full, 1'b0);
    check("rst_prog_data", dif.tcam_program_data, '0);
    dif.rq0_valid = 0;
    @(negedge clk);
    reset = 1;

    drive(0, 2'b00, 8'd5, W'(8'hA5), W'(8'hFF));
    wait_idle();
    check("count_after_add5", dif.entry_count, 9'd1);

    do_reset();
    fork
      drive(0, 2'b00, 8'd10, rv(), rv());
      drive(1, 2'b00, 8'd11, rv(), rv());
    join
    fork
      drive(0, 2'b00, 8'd12, rv(), rv());
      drive(1, 2'b00, 8'd13, rv(), rv());
    join
    drive(0, 2'b00, 8'd14, rv(), rv());
    fork
      drive(0, 2'b01, 8'd14, rv(), rv());
      drive(1, 2'b01, 8'd10, rv(), rv());
    join
    wait_idle();

    do_reset();
    repeat (3) drive(0, 2'b10, 8'd0, rv(), rv());
    drive(1, 2'b01, 8'd1, rv(), rv());
    drive(0, 2'b10, 8'd77, rv(), rv());
    wait_idle();
    check("count_after_alloc", dif.entry_count, 9'd3);

    drive(0, 2'b01, 8'd9, rv(), rv());
    drive(1, 2'b00, 8'd0, rv(), rv());
    drive(0, 2'b11, 8'd3, rv(), rv());
    wait_idle();
    check("count_after_err", dif.entry_count, 9'd3);

    dif.rsp_ready = 0;
    drive(0, 2'b00, 8'd20, rv(), rv());
    fork
      drive(1, 2'b00, 8'd21, rv(), rv());
    join_none
    n = 0;
    while (!dif.rsp_valid && n < 20) begin @(negedge clk); n++; end
    check("bp_rsp_seen", dif.rsp_valid, 1'b1);
    g0 = grants;
    repeat (10) @(negedge clk);
    check("bp_no_grant", grants, g0);
    check("bp_rsp_held", dif.rsp_valid, 1'b1);
    dif.rsp_ready = 1;
    wait fork;
    wait_idle();

    rand_bp = 1;
    for (int k = 0; k < 40; k++) begin
      m = $urandom_range(2);
      n = $urandom_range(9);
      op = (n < 4) ? 2'b00 : (n < 7) ? 2'b01 : (n < 9) ? 2'b10 : 2'b11;
      if (m == 2) begin
        fork
          drive(0, op, AW'($urandom_range(15)), rv(), rv());
          drive(1, 2'($urandom_range(3)), AW'($urandom_range(15)), rv(), rv());
        join
      end else begin
        drive(m[0], op, AW'($urandom_range(15)), rv(), rv());
      end
    end
    rand_bp = 0;
    @(posedge clk); #2;
    dif.rsp_ready = 1;
    wait_idle();

    do_reset();
    r = 0;
    repeat (D) begin
      drive(r, 2'b10, AW'($urandom_range(255)), rv(), rv());
      r = ~r;
    end
    drive(0, 2'b10, 8'd0, rv(), rv());
    wait_idle();
    check("full_flag", dif.tcam_full, 1'b1);
    check("full_count", dif.entry_count, 9'd256);

    do_reset();
    drive(0, 2'b00, 8'd7, rv(), rv());
    n = 0;
    while (!dif.tcam_program_enable && n < 10) begin @(negedge clk); n++; end
    check("mid_write_seen", dif.tcam_program_enable, 1'b1);
    reset = 0;
    clear_model();
    #1;
    check("mid_rst_prog_en", dif.tcam_program_enable, 1'b0);
    check("mid_rst_rsp_valid", dif.rsp_valid, 1'b0);
    check("mid_rst_count", dif.entry_count, '0);
    check("mid_rst_unit_sel", dif.tcam_unit_sel, '0);
    repeat (2) @(negedge clk);
    reset = 1;
    repeat (8) @(negedge clk);
    check("post_rst_no_rsp", dif.rsp_valid, 1'b0);
    check("post_rst_count", dif.entry_count, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
